systolic_array: RTL and testbench

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

---
 rtl/systolic_array_pkg.sv | 9 +
 rtl/systolic_array_pe.sv | 50 +++++
 rtl/systolic_array.sv | 86 ++++++++
 tb/tb_systolic_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared sizing constants for the 2x2 weight-stationary-free systolic multiply array.
package systolic_array_pkg;
   localparam int DATA_W       = 8;
   localparam int ACC_W        = 16;
   localparam int ARRAY_N      = 2;
   localparam int VALID_CYCLES = 4;
   localparam int CNT_W        = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/systolic_array_pe.sv
// One processing element: multiply-accumulate, forwarding a right and b down.
module mmu_pe
   import systolic_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [ACC_W-1:0]  prod;
   logic [ACC_W:0]    sum;

   always_comb begin
      prod = ACC_W'(a_in) * ACC_W'(b_in);
      sum  = {1'b0, acc_q} + {1'b0, prod};
      acc_d = sum[ACC_W-1:0];
      a_d   = a_in;
      b_d   = b_in;
      if (clear) begin
         acc_d = '0;
         a_d   = '0;
         b_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   // Raw carry-out of this cycle's sum; the top decides whether clear masks it.
   assign ovf   = sum[ACC_W];
   assign acc   = acc_q;
   assign a_out = a_q;
   assign b_out = b_q;
endmodule

// File: rtl/systolic_array.sv
// 2x2 systolic matrix multiplier with completion counter and sticky wrap flag.
module systolic_array
   import systolic_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] a_data0,
   input  logic [DATA_W-1:0] a_data1,
   input  logic [DATA_W-1:0] b_data0,
   input  logic [DATA_W-1:0] b_data1,
   output logic [ACC_W-1:0]  c00,
   output logic [ACC_W-1:0]  c01,
   output logic [ACC_W-1:0]  c10,
   output logic [ACC_W-1:0]  c11,
   output logic              c_valid,
   output logic              overflow
);
   logic [ARRAY_N-1:0][DATA_W-1:0]              a_src, b_src;
   logic [ARRAY_N-1:0][ARRAY_N-1:0][DATA_W-1:0] a_in_w, b_in_w, a_out_w, b_out_w;
   logic [ARRAY_N-1:0][ARRAY_N-1:0][ACC_W-1:0]  acc_w;
   logic [ARRAY_N-1:0][ARRAY_N-1:0]             pe_ovf;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   assign a_src = {a_data1, a_data0};
   assign b_src = {b_data1, b_data0};

   // Left column takes a from the row streams, top row takes b from the column streams.
   for (genvar r = 0; r < ARRAY_N; r++) begin : g_row
      for (genvar c = 0; c < ARRAY_N; c++) begin : g_col
         if (c == 0) begin : g_a_edge
            assign a_in_w[r][c] = a_src[r];
         end else begin : g_a_int
            assign a_in_w[r][c] = a_out_w[r][c-1];
         end
         if (r == 0) begin : g_b_edge
            assign b_in_w[r][c] = b_src[c];
         end else begin : g_b_int
            assign b_in_w[r][c] = b_out_w[r-1][c];
         end
         mmu_pe u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .a_in  (a_in_w[r][c]),
            .b_in  (b_in_w[r][c]),
            .a_out (a_out_w[r][c]),
            .b_out (b_out_w[r][c]),
            .acc   (acc_w[r][c]),
            .ovf   (pe_ovf[r][c])
         );
      end
   end

   // Operands leaving the right/bottom edge go nowhere.
   logic unused_edge;
   assign unused_edge = ^{a_out_w[0][ARRAY_N-1], a_out_w[1][ARRAY_N-1],
                          b_out_w[ARRAY_N-1][0], b_out_w[ARRAY_N-1][1]};

   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      ovf_d = ovf_q | (|pe_ovf);
      if (clear) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign c00      = acc_w[0][0];
   assign c01      = acc_w[0][1];
   assign c10      = acc_w[1][0];
   assign c11      = acc_w[1][1];
   assign c_valid  = (cnt_q >= CNT_W'(VALID_CYCLES));
   assign overflow = ovf_q;
endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: products, wrap, clears, async reset, saturation.
module tb_systolic_array;
   logic        clk, rst_n, clear;
   logic [7:0]  a_data0, a_data1, b_data0, b_data1;
   logic [15:0] c00, c01, c10, c11;
   logic        c_valid, overflow;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] c_all [4];

   systolic_array dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .a_data0(a_data0), .a_data1(a_data1), .b_data0(b_data0), .b_data1(b_data1),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .c_valid(c_valid), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      c_all[0] = c00;
      c_all[1] = c01;
      c_all[2] = c10;
      c_all[3] = c11;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a0, a1, b0, b1);
      a_data0 = a0; a_data1 = a1; b_data0 = b0; b_data1 = b1;
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      drive(0, 0, 0, 0);
      clear = 1'b0;
   endtask

   // Skewed feed of W x I over array cycles 0..2 plus one drain cycle.
   task automatic run_mm(input logic [7:0] w00, w01, w10, w11, i00, i01, i10, i11);
      drive(w00, 0, i00, 0);
      drive(w01, w10, i10, i01);
      drive(0, w11, 0, i11);
      drive(0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0;
      a_data0 = 0; a_data1 = 0; b_data0 = 0; b_data1 = 0;
      #12;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd0) begin
            errors++; $display("FAIL reset_c%0d: got %0d expected 0", k, c_all[k]);
         end
      end
      checks++;
      if ({c_valid, overflow} !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got %b expected 00", {c_valid, overflow});
      end
      #5 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [15:0] exp [4];
      exp = '{16'd19, 16'd22, 16'd43, 16'd50};
      do_clear();
      drive(1, 0, 5, 0);
      drive(2, 3, 7, 6);
      drive(0, 4, 0, 8);
      checks++;
      if (c_valid !== 1'b0) begin
         errors++; $display("FAIL basic_valid_early: got %b expected 0", c_valid);
      end
      drive(0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== exp[k]) begin
            errors++; $display("FAIL basic_c%0d: got %0d expected %0d", k, c_all[k], exp[k]);
         end
      end
      checks++;
      if ({c_valid, overflow} !== 2'b10) begin
         errors++; $display("FAIL basic_flags: got %b expected 10", {c_valid, overflow});
      end
   endtask

   task automatic test_wrap();
      do_clear();
      run_mm(255, 255, 255, 255, 255, 255, 255, 255);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd64514) begin
            errors++; $display("FAIL wrap_c%0d: got %0d expected 64514", k, c_all[k]);
         end
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL wrap_overflow: got %b expected 1", overflow);
      end
      repeat (5) drive(0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd64514) begin
            errors++; $display("FAIL wrap_hold_c%0d: got %0d expected 64514", k, c_all[k]);
         end
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL wrap_sticky: got %b expected 1", overflow);
      end
   endtask

   task automatic test_clear_priority();
      // Accumulators hold 64514, so this edge would wrap if clear lost priority.
      clear = 1'b1;
      drive(255, 255, 255, 255);
      clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd0) begin
            errors++; $display("FAIL clrpri_c%0d: got %0d expected 0", k, c_all[k]);
         end
      end
      checks++;
      if ({c_valid, overflow} !== 2'b00) begin
         errors++; $display("FAIL clrpri_flags: got %b expected 00", {c_valid, overflow});
      end
   endtask

   task automatic test_midrun_clear();
      do_clear();
      drive(1, 0, 5, 0);
      drive(2, 3, 7, 6);
      do_clear();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd0) begin
            errors++; $display("FAIL midclr_c%0d: got %0d expected 0", k, c_all[k]);
         end
      end
      drive(2, 0, 1, 0);
      drive(0, 0, 1, 1);
      drive(0, 2, 0, 1);
      checks++;
      if (c_valid !== 1'b0) begin
         errors++; $display("FAIL midclr_valid_edge3: got %b expected 0", c_valid);
      end
      drive(0, 0, 0, 0);
      checks++;
      if (c_valid !== 1'b1) begin
         errors++; $display("FAIL midclr_valid_edge4: got %b expected 1", c_valid);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd2) begin
            errors++; $display("FAIL midclr_c%0d: got %0d expected 2", k, c_all[k]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] exp [4];
      exp = '{16'd19, 16'd22, 16'd43, 16'd50};
      do_clear();
      drive(1, 0, 5, 0);
      drive(2, 3, 7, 6);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== 16'd0) begin
            errors++; $display("FAIL areset_c%0d: got %0d expected 0", k, c_all[k]);
         end
      end
      checks++;
      if ({c_valid, overflow} !== 2'b00) begin
         errors++; $display("FAIL areset_flags: got %b expected 00", {c_valid, overflow});
      end
      tick();
      #3 rst_n = 1'b1;
      run_mm(1, 2, 3, 4, 5, 6, 7, 8);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== exp[k]) begin
            errors++; $display("FAIL areset_rerun_c%0d: got %0d expected %0d", k, c_all[k], exp[k]);
         end
      end
      checks++;
      if ({c_valid, overflow} !== 2'b10) begin
         errors++; $display("FAIL areset_rerun_flags: got %b expected 10", {c_valid, overflow});
      end
   endtask

   task automatic test_saturation();
      logic [15:0] exp [4];
      exp = '{16'd19, 16'd22, 16'd43, 16'd50};
      for (int n = 0; n < 20; n++) begin
         drive(0, 0, 0, 0);
         checks++;
         if (c_valid !== 1'b1) begin
            errors++; $display("FAIL sat_valid_edge%0d: got %b expected 1", n, c_valid);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_all[k] !== exp[k]) begin
            errors++; $display("FAIL sat_c%0d: got %0d expected %0d", k, c_all[k], exp[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_clear_priority();
      test_midrun_clear();
      test_async_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
